// File: rtl/spi_cmd_framer.sv
// SD-style command framer: sends a 6-byte command frame (cmd, 4 arg bytes, CRC7)
// to the SPI byte controller, then waits for one response byte with a timeout.
module spi_cmd_framer #(
  parameter int unsigned STB_CYCLES   = 4,
  parameter int unsigned RESP_TIMEOUT = 50000
) (
  input  logic        CLK50,
  input  logic        RST_N,
  input  logic        CMD_STB,
  input  logic [5:0]  CMD_IDX,
  input  logic [31:0] CMD_ARG,
  output logic        CMD_BUSY,
  output logic        CMD_DONE,
  output logic [7:0]  CMD_RESP,
  output logic        CMD_TMO,
  output logic        W_STB,
  output logic [7:0]  W_DATA,
  input  logic        W_ACK,
  input  logic        R_STB,
  input  logic [7:0]  R_DATA,
  output logic        CS
);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_SEND_STB, S_SEND_WAIT, S_RESP_WAIT, S_DONE
  } state_t;

  localparam logic [15:0] SETUP_LAST = 16'(STB_CYCLES - 1);
  localparam logic [15:0] STB_LAST   = 16'(STB_CYCLES);
  localparam logic [15:0] TMO_LAST   = 16'(RESP_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [6:0]  crc_q, crc_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic        ack_q, ack_prev_q;
  logic        cs_q, cs_d;
  logic        w_stb_q, w_stb_d;
  logic [7:0]  w_data_q, w_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  resp_q, resp_d;
  logic        tmo_q, tmo_d;
  logic        ack_edge;
  logic [15:0] timer_inc;
  logic [7:0]  next_byte;

  // CRC7 (x^7 + x^3 + 1) advanced over one byte, MSB first
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] b);
    logic [6:0] c;
    logic [7:0] d;
    logic       fb;
    c = crc;
    d = b;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[6] ^ d[7];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      d  = {d[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] n, input logic [5:0] idx,
                                            input logic [31:0] arg);
    logic [7:0] b;
    case (n)
      3'd0:    b = {2'b01, idx};
      3'd1:    b = arg[31:24];
      3'd2:    b = arg[23:16];
      3'd3:    b = arg[15:8];
      3'd4:    b = arg[7:0];
      default: b = '0;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    crc_d     = crc_q;
    idx_d     = idx_q;
    arg_d     = arg_q;
    cs_d      = cs_q;
    w_stb_d   = w_stb_q;
    w_data_d  = w_data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    resp_d    = resp_q;
    tmo_d     = tmo_q;
    ack_edge  = ack_q & ~ack_prev_q;
    timer_inc = (timer_q == '1) ? timer_q : timer_q + 16'd1;
    next_byte = frame_byte(cnt_q + 3'd1, idx_q, arg_q);

    case (state_q)
      S_IDLE: begin
        if (CMD_STB) begin
          idx_d   = CMD_IDX;
          arg_d   = CMD_ARG;
          crc_d   = '0;
          cnt_d   = '0;
          timer_d = '0;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          tmo_d   = 1'b0;
          resp_d  = 8'hFF;
          state_d = S_CS_SETUP;
        end
      end
      S_CS_SETUP: begin
        if (timer_q == SETUP_LAST) begin
          w_data_d = {2'b01, idx_q};
          crc_d    = crc7_byte(crc_q, {2'b01, idx_q});
          timer_d  = '0;
          state_d  = S_SEND_STB;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_SEND_STB: begin
        if (timer_q == STB_LAST) begin
          w_stb_d = 1'b0;
          timer_d = '0;
          state_d = S_SEND_WAIT;
        end else begin
          w_stb_d = 1'b1;
          timer_d = timer_inc;
        end
      end
      S_SEND_WAIT: begin
        if (ack_edge) begin
          timer_d = '0;
          if (cnt_q != 3'd5) begin
            cnt_d = cnt_q + 3'd1;
            // crc_q already covers B0..B4 once the fifth argument-side byte is out
            if (cnt_q == 3'd4) begin
              w_data_d = {crc_q, 1'b1};
            end else begin
              w_data_d = next_byte;
              crc_d    = crc7_byte(crc_q, next_byte);
            end
            state_d = S_SEND_STB;
          end else begin
            state_d = S_RESP_WAIT;
          end
        end
      end
      S_RESP_WAIT: begin
        if (R_STB) begin
          resp_d  = R_DATA;
          tmo_d   = 1'b0;
          done_d  = 1'b1;
          cs_d    = 1'b1;
          state_d = S_DONE;
        end else if (timer_q == TMO_LAST) begin
          resp_d  = 8'hFF;
          tmo_d   = 1'b1;
          done_d  = 1'b1;
          cs_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        cs_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      timer_q    <= '0;
      crc_q      <= '0;
      idx_q      <= '0;
      arg_q      <= '0;
      ack_q      <= 1'b0;
      ack_prev_q <= 1'b0;
      cs_q       <= 1'b1;
      w_stb_q    <= 1'b0;
      w_data_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      resp_q     <= 8'hFF;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      crc_q      <= crc_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
      ack_q      <= W_ACK;
      ack_prev_q <= ack_q;
      cs_q       <= cs_d;
      w_stb_q    <= w_stb_d;
      w_data_q   <= w_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      resp_q     <= resp_d;
      tmo_q      <= tmo_d;
    end
  end

  assign CS       = cs_q;
  assign W_STB    = w_stb_q;
  assign W_DATA   = w_data_q;
  assign CMD_BUSY = busy_q;
  assign CMD_DONE = done_q;
  assign CMD_RESP = resp_q;
  assign CMD_TMO  = tmo_q;

endmodule

// File: doc/spi_cmd_framer.md
Name: spi_cmd_framer

Overview:
Command framer that sits directly upstream of the SPI byte controller (W_STB/W_DATA/W_ACK, R_STB/R_DATA) and drives the top-level chip select.
- Takes a 6-bit command index and a 32-bit argument, and emits an SD-style 6-byte frame to the controller: command byte, 4 argument bytes MSB first, then CRC7 byte.
- Then waits for one response byte, with a timeout, and reports the result to the host logic.

Parameters:
STB_CYCLES, 4, CLK50 cycles W_STB is held high per byte and CS setup time; must cover at least one full SCLK period of the controller.
RESP_TIMEOUT, 50000, CLK50 cycles to wait for R_STB after the last byte's W_ACK; must fit in 16 bits.

Ports:
CLK50  in  1  system clock, 50 MHz
RST_N  in  1  asynchronous active-low reset
CMD_STB  in  1  one-cycle start request, honoured only when idle
CMD_IDX  in  6  command index, sampled with CMD_STB
CMD_ARG  in  32  command argument, sampled with CMD_STB
CMD_BUSY  out  1  high from accepted CMD_STB until the cycle after CMD_DONE
CMD_DONE  out  1  one-cycle pulse at end of transaction
CMD_RESP  out  8  response byte, valid from CMD_DONE until next accepted command
CMD_TMO  out  1  timeout flag, valid with CMD_RESP
W_STB  out  1  byte strobe to SPI controller
W_DATA  out  8  byte to SPI controller
W_ACK  in  1  byte-sent acknowledge from SPI controller
R_STB  in  1  received-byte strobe from SPI controller
R_DATA  in  8  received byte from SPI controller
CS  out  1  chip select, active low

Behaviour:
- Reset values (asynchronous on RST_N low, effective immediately mid-operation):
  - CS=1, W_STB=0, W_DATA=0, CMD_BUSY=0, CMD_DONE=0, CMD_RESP=8'hFF, CMD_TMO=0.
  - State=IDLE, byte counter=0, CRC=0, timers=0.
- Frame bytes:
  - B0={2'b01,CMD_IDX}; B1..B4=CMD_ARG[31:24], [23:16], [15:8], [7:0]; B5={CRC7,1'b1}.
- CRC7:
  - Polynomial x^7+x^3+1, init 7'h00.
  - Computed MSB-first over B0..B4 as each byte is loaded into W_DATA. A precomputed result is also acceptable if the values match.
- W_ACK is registered once and edge-detected; only a 0->1 transition counts as an ack.
- States:
  - IDLE: CS=1, CMD_BUSY=0.
    - On CMD_STB: latch IDX/ARG, clear CRC, set CMD_BUSY=1, CS=0, clear CMD_TMO, set CMD_RESP=8'hFF, go to CS_SETUP.
  - CS_SETUP: count STB_CYCLES cycles, then load W_DATA=B0 and go to SEND_STB.
  - SEND_STB: W_STB=1 for exactly STB_CYCLES cycles, then W_STB=0 and go to SEND_WAIT.
  - SEND_WAIT: wait for the W_ACK rising edge.
    - If byte counter<5: increment it, load the next byte, go to SEND_STB.
    - If byte counter=5: clear the timer, go to RESP_WAIT.
  - RESP_WAIT: timer increments each cycle.
    - On R_STB: CMD_RESP=R_DATA, CMD_TMO=0, go to DONE.
    - Else, when the timer reaches RESP_TIMEOUT-1: CMD_RESP=8'hFF, CMD_TMO=1, go to DONE.
    - R_STB wins if both occur in the same cycle.
  - DONE: CMD_DONE=1 for one cycle, CS=1, byte counter=0, go to IDLE.
    - CMD_BUSY drops on the next cycle.
- Ignored inputs:
  - CMD_STB while not in IDLE is ignored, and no latch occurs.
  - CMD_STB in the same cycle as CMD_DONE is ignored.
  - R_STB outside RESP_WAIT is ignored.
  - A W_ACK edge outside SEND_WAIT is ignored.
- The byte counter is 3 bits and never exceeds 5. The timer is 16 bits and saturates; it does not wrap.
- Latency: the first W_STB rises STB_CYCLES+1 cycles after the accepted CMD_STB.
- No combinational path from any input to any output.

Test Plan:
1. CMD_STB, IDX=0, ARG=0, with a controller model acking each byte:
   - Required: W_DATA sequence 40 00 00 00 00 95.
   - Required: CS low throughout. Model then returns R_DATA=01 -> CMD_RESP=01, CMD_TMO=0, one CMD_DONE pulse, CS=1.
2. IDX=8, ARG=32'h000001AA:
   - Required: bytes 48 00 00 01 AA 87.
   - Response 01 -> CMD_RESP=01.
3. IDX=55, ARG=0, no R_STB ever:
   - Required: CMD_DONE exactly RESP_TIMEOUT cycles after the 6th ack, with CMD_TMO=1 and CMD_RESP=FF.
4. Second CMD_STB (IDX=17) during byte 2 of an IDX=0 frame, plus R_STB with R_DATA=AA during SEND_WAIT:
   - Required: frame unchanged (40 00 00 00 00 95) and the spurious byte ignored.
   - Final CMD_RESP equals the later R_DATA=00.
5. RST_N low during SEND_STB of byte 3:
   - Required: CS=1, W_STB=0, CMD_BUSY=0 in the same cycle.
   - After release, a new IDX=0 command produces a correct full frame.
6. W_ACK held high across two bytes without a falling edge:
   - Required: only one byte advance.
   - The next byte is sent only after W_ACK falls and rises again.
